// File: rtl/weight_loader.sv
// Weight loader: streams one N-row weight tile into the top row of the systolic array.
// Latency: each accepted beat appears on the outputs one cycle after its handshake; sw_ready N cycles after the last beat.
// Backpressure: in_ready drops after the last beat and stays low until sw_ack promotes the tile.
module weight_loader #(
  parameter  int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter  int DATA_WIDTH_IN        = 8,
  localparam int INDEX_WIDTH          = $clog2(SYSTOLIC_ARRAY_WIDTH)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0] in_data,
  input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]               col_mask,
  output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_IN-1:0] out_weight,
  output logic [SYSTOLIC_ARRAY_WIDTH*INDEX_WIDTH-1:0]   out_index,
  output logic [SYSTOLIC_ARRAY_WIDTH-1:0]               out_accept_w,
  output logic                                          sw_ready,
  input  logic                                          sw_ack,
  output logic                                          busy
);

  localparam int N  = SYSTOLIC_ARRAY_WIDTH;
  localparam int DW = DATA_WIDTH_IN;
  localparam int IW = INDEX_WIDTH;

  // Last row index of a tile, and the drain count at which the deepest row has captured.
  localparam logic [IW-1:0] LAST_ROW   = IW'(N - 1);
  localparam logic [IW:0]   LAST_DRAIN = (IW + 1)'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    READY = 2'd3
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     row_q;
  logic [IW:0]       drain_q;
  logic [N-1:0]      mask_q;
  logic [N*DW-1:0]   out_weight_q;
  logic [N*IW-1:0]   out_index_q;
  logic [N-1:0]      out_accept_w_q;
  logic              sw_ready_q;
  logic              in_ready_q;
  logic              busy_q;

  logic              hs_d;
  logic [N-1:0]      beat_mask_d;

  // Handshake qualification and the mask that applies to the current beat
  // (beat 0 uses col_mask directly since it is latched on that same edge).
  always_comb begin
    hs_d        = in_valid & in_ready_q;
    beat_mask_d = (state_q == IDLE) ? col_mask : mask_q;
  end

  // Tile FSM with registered stream outputs, handshake ready and switch-ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      row_q          <= '0;
      drain_q        <= '0;
      mask_q         <= '0;
      out_weight_q   <= '0;
      out_index_q    <= '0;
      out_accept_w_q <= '0;
      sw_ready_q     <= 1'b0;
      in_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      // Stream outputs are zero on every cycle without an accepted beat.
      out_weight_q   <= '0;
      out_index_q    <= '0;
      out_accept_w_q <= '0;

      if (hs_d) begin
        for (int c = 0; c < N; c++) begin
          if (beat_mask_d[c]) begin
            out_weight_q[c*DW +: DW] <= in_data[c*DW +: DW];
            out_index_q[c*IW +: IW]  <= row_q;
            out_accept_w_q[c]        <= 1'b1;
          end
        end
      end

      case (state_q)
        IDLE, LOAD: begin
          if (hs_d) begin
            if (state_q == IDLE) begin
              mask_q <= col_mask;
            end
            busy_q <= 1'b1;
            if (row_q == LAST_ROW) begin
              row_q      <= '0;
              drain_q    <= '0;
              in_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end else begin
              row_q   <= row_q + IW'(1);
              state_q <= LOAD;
            end
          end
        end
        DRAIN: begin
          drain_q <= drain_q + (IW + 1)'(1);
          if (drain_q == LAST_DRAIN) begin
            sw_ready_q <= 1'b1;
            state_q    <= READY;
          end
        end
        READY: begin
          if (sw_ack) begin
            sw_ready_q <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_weight   = out_weight_q;
  assign out_index    = out_index_q;
  assign out_accept_w = out_accept_w_q;
  assign sw_ready     = sw_ready_q;
  assign in_ready     = in_ready_q;
  assign busy         = busy_q;

endmodule
